// File: rtl/instr_fetch.sv
// Instruction fetch front end: sequences the PC, requests words from a one-cycle-latency ROM and
// queues them in a small prefetch FIFO for issue to the controller over valid/ready.
//
// state  | meaning
// S_RUN  | fetching whenever buffer + in-flight leaves room
// S_HALT | halt word captured; no requests until redirect or reset
module instr_fetch #(
  parameter int unsigned     PC_W       = 8,
  parameter int unsigned     DEPTH      = 2,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [8:0]      HALT_INSTR = 9'h1FF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [8:0]      instr_out,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  output logic            done
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;
  logic            inflight;
  logic [8:0]      buf_instr [DEPTH];
  logic [PC_W-1:0] buf_pc    [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            pop, push, halt_hit, room;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  // A redirect discards the response arriving this cycle.
  assign push        = inflight & ~redirect;
  assign halt_hit    = push & (imem_data == HALT_INSTR);
  assign room        = ({1'b0, count} + (CW+1)'(inflight)) < ((CW+1)'(DEPTH) + (CW+1)'(pop));
  assign imem_en     = ~reset & (state == S_RUN) & ~redirect & room;
  assign imem_addr   = pc;
  assign instr_out   = instr_valid ? buf_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : '0;

  always_comb begin
    state_nxt = state;
    if (redirect)      state_nxt = S_RUN;
    else if (halt_hit) state_nxt = S_HALT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= START_ADDR;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      if (imem_en) begin
        pc     <= pc + 1'b1;
        req_pc <= pc;
      end
      // A request issued on the same edge the halt word lands is dropped.
      inflight <= imem_en & ~halt_hit;
      if (push) wr_ptr <= inc_ptr(wr_ptr);
      if (pop)  rd_ptr <= inc_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
      if (pop && instr_out == HALT_INSTR) done <= 1'b1;
    end
  end

  // Payload storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_data;
      buf_pc[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized ready/redirect/reset traffic.
module tb_instr_fetch;

  localparam int PC_W = 8;
  localparam int DEPTH = 2;
  localparam logic [8:0] HALT = 9'h1FF;

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data = '0;
  logic [8:0]      instr_out;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            redirect;
  logic [PC_W-1:0] redirect_target;
  logic            done;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] rom [256];

  instr_fetch #(.PC_W(PC_W), .DEPTH(DEPTH), .START_ADDR(8'h00), .HALT_INSTR(HALT)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_target(redirect_target), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word for the address requested at an edge is presented after that edge.
  always @(posedge clk) if (imem_en) imem_data <= rom[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program order as a queue of {word, pc}.
  typedef struct {logic [8:0] instr; logic [7:0] pc;} ent_t;
  ent_t       q[$];
  bit         m_inflight = 0;
  bit         m_halted = 0;
  bit         m_done = 0;
  logic [7:0] m_pc = '0;
  logic [7:0] m_req_pc = '0;

  always @(negedge clk) begin
    ent_t e;
    bit ev, pop, een, hit;
    if (reset) begin
      q.delete();
      m_inflight = 0; m_halted = 0; m_done = 0; m_pc = 8'h00; m_req_pc = 8'h00;
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_en", 32'(imem_en), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_out", 32'(instr_out), 0);
      chk("rst_pc", 32'(instr_pc), 0);
    end else begin
      ev  = (q.size() != 0);
      pop = ev && instr_ready;
      een = !m_halted && !redirect && ((q.size() + int'(m_inflight)) < (DEPTH + int'(pop)));
      chk("valid", 32'(instr_valid), 32'(ev));
      chk("imem_en", 32'(imem_en), 32'(een));
      chk("done", 32'(done), 32'(m_done));
      chk("occupancy", 32'(dut.count), 32'(q.size()));
      if (ev) begin
        chk("instr_out", 32'(instr_out), 32'(q[0].instr));
        chk("instr_pc", 32'(instr_pc), 32'(q[0].pc));
      end
      if (een) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      if (redirect) begin
        q.delete();
        m_inflight = 0; m_pc = redirect_target; m_halted = 0; m_done = 0;
      end else begin
        hit = 0;
        if (pop) begin
          e = q.pop_front();
          if (e.instr == HALT) m_done = 1;
        end
        if (m_inflight) begin
          e.instr = rom[m_req_pc];
          e.pc = m_req_pc;
          q.push_back(e);
          if (e.instr == HALT) begin m_halted = 1; hit = 1; end
        end
        if (een) begin
          m_req_pc = m_pc;
          m_pc = m_pc + 8'd1;
          m_inflight = !hit;
        end else m_inflight = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [8:0] w, input logic [7:0] p);
    chk({name, "_valid"}, 32'(instr_valid), 1);
    chk({name, "_out"}, 32'(instr_out), 32'(w));
    chk({name, "_pc"}, 32'(instr_pc), 32'(p));
  endtask

  task automatic pulse_redirect(input logic [7:0] tgt, input logic rdy);
    @(posedge clk); #1 redirect = 1'b1; redirect_target = tgt; instr_ready = rdy;
    @(negedge clk);
    chk("redir_en_low", 32'(imem_en), 0);
    @(posedge clk); #1 redirect = 1'b0; instr_ready = 1'b1;
  endtask

  initial begin
    logic [8:0] v;
    reset = 1'b1; redirect = 1'b0; redirect_target = '0; instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = 9'($urandom_range(0, 511));
      rom[i] = (v == HALT) ? 9'h000 : v;
    end
    rom[0] = 9'h012; rom[1] = 9'h034; rom[2] = 9'h056; rom[3] = 9'h078;
    rom[4] = 9'h09A; rom[5] = HALT;

    @(negedge clk);

    // Basic stream
    instr_ready = 1'b1;
    do_reset();
    @(negedge clk); chk("p1_en0", 32'(imem_en), 1); chk("p1_addr0", 32'(imem_addr), 0);
    chk("p1_v0", 32'(instr_valid), 0);
    @(negedge clk); chk("p1_addr1", 32'(imem_addr), 1); chk("p1_v1", 32'(instr_valid), 0);
    @(negedge clk); chk_out("p1_t0", 9'h012, 8'h00);
    @(negedge clk); chk_out("p1_t1", 9'h034, 8'h01);
    @(negedge clk); chk_out("p1_t2", 9'h056, 8'h02);
    @(negedge clk); chk_out("p1_t3", 9'h078, 8'h03);

    // Backpressure
    instr_ready = 1'b0;
    do_reset();
    @(negedge clk); chk("p2_addr0", 32'(imem_addr), 0);
    @(negedge clk); chk("p2_addr1", 32'(imem_addr), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_out("p2_hold", 9'h012, 8'h00);
      chk("p2_en_low", 32'(imem_en), 0);
    end
    @(posedge clk); #1 instr_ready = 1'b1;
    @(negedge clk); chk_out("p2_r0", 9'h012, 8'h00); chk("p2_addr2", 32'(imem_addr), 2);
    @(negedge clk); chk_out("p2_r1", 9'h034, 8'h01);
    @(negedge clk); chk_out("p2_r2", 9'h056, 8'h02);

    // Redirect while 0x034 at head and 0x056 in flight
    instr_ready = 1'b1;
    do_reset();
    @(negedge clk); @(negedge clk);
    @(negedge clk); chk_out("p3_t0", 9'h012, 8'h00);
    @(posedge clk); #1 redirect = 1'b1; redirect_target = 8'h40; instr_ready = 1'b0;
    @(negedge clk); chk_out("p3_head", 9'h034, 8'h01); chk("p3_en_low", 32'(imem_en), 0);
    @(posedge clk); #1 redirect = 1'b0; instr_ready = 1'b1;
    @(negedge clk); chk("p3_v_a", 32'(instr_valid), 0); chk("p3_addr40", 32'(imem_addr), 32'h40);
    @(negedge clk); chk("p3_v_b", 32'(instr_valid), 0);
    @(negedge clk); chk_out("p3_t40", rom[8'h40], 8'h40);
    @(negedge clk); chk_out("p3_t41", rom[8'h41], 8'h41);

    // PC wrap
    pulse_redirect(8'hFE, 1'b1);
    @(negedge clk); chk("p4_addrFE", 32'(imem_addr), 32'hFE);
    @(negedge clk); chk("p4_addrFF", 32'(imem_addr), 32'hFF);
    @(negedge clk); chk_out("p4_tFE", rom[8'hFE], 8'hFE); chk("p4_addr00", 32'(imem_addr), 0);
    @(negedge clk); chk_out("p4_tFF", rom[8'hFF], 8'hFF);
    @(negedge clk); chk_out("p4_t00", 9'h012, 8'h00);

    // Halt at address 5
    instr_ready = 1'b1;
    do_reset();
    repeat (7) @(negedge clk);
    chk_out("p5_t4", 9'h09A, 8'h04);
    @(negedge clk); chk_out("p5_halt", HALT, 8'h05); chk("p5_en_low", 32'(imem_en), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("p5_done", 32'(done), 1);
      chk("p5_idle_en", 32'(imem_en), 0);
      chk("p5_idle_v", 32'(instr_valid), 0);
    end
    pulse_redirect(8'h00, 1'b0);
    @(negedge clk); chk("p5_done_clr", 32'(done), 0); chk("p5_resume", 32'(imem_en), 1);
    chk("p5_resume_addr", 32'(imem_addr), 0);

    // Async reset mid-stream with the buffer full
    instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("p6_full", 32'(dut.count), DEPTH);
    @(posedge clk); #3 reset = 1'b1;
    #1 chk("p6_v", 32'(instr_valid), 0); chk("p6_done", 32'(done), 0);
    chk("p6_en", 32'(imem_en), 0);
    @(posedge clk); #1 reset = 1'b0; instr_ready = 1'b1;
    @(negedge clk); chk("p6_restart", 32'(imem_addr), 0); chk("p6_restart_en", 32'(imem_en), 1);
    @(negedge clk);
    @(negedge clk); chk_out("p6_t0", 9'h012, 8'h00);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: redirect_target = 8'hFE;
        1: redirect_target = 8'h00;
        2: redirect_target = 8'h03;
        default: redirect_target = 8'($urandom_range(0, 255));
      endcase
    end
    @(posedge clk); #1 reset = 1'b0; redirect = 1'b0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch front end. Sequences the program counter, reads 9-bit instructions from the instruction memory, and issues them one at a time to the controller over a valid/ready handshake.
- Sits between the instruction ROM and the controller's 9-bit instruction input.
- Handles branch/jump redirects and halt detection. Holds a small prefetch buffer so issue is not stalled by memory latency.

Parameters:
- PC_W, 8, program counter and instruction-address width.
- DEPTH, 2, prefetch buffer entries (≥2).
- START_ADDR, 0, PC value after reset.
- HALT_INSTR, 9'h1FF, encoding that stops fetching.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_en  out  1  read request to instruction memory this cycle.
- imem_addr  out  PC_W  read address; equals current PC.
- imem_data  in  9  instruction word; valid in the cycle after the one where imem_en was high.
- instr_out  out  9  head-of-buffer instruction to controller.
- instr_pc  out  PC_W  address of instr_out.
- instr_valid  out  1  instr_out/instr_pc valid.
- instr_ready  in  1  controller accepts; transfer when instr_valid & instr_ready.
- redirect  in  1  taken branch/jump; one-cycle pulse.
- redirect_target  in  PC_W  new PC when redirect high.
- done  out  1  sticky: HALT_INSTR has been transferred.

Behaviour:
- Reset (async, any time, including mid-fetch):
  - PC=START_ADDR; buffer empty; in-flight flag=0; halted=0.
  - Outputs: instr_valid=0, instr_out=0, instr_pc=0, done=0, imem_en=0.
  - Output must not glitch high during reset.
- Issue rule:
  - imem_en = !reset_active & !halted & !redirect & (occupancy + inflight − pop < DEPTH).
  - pop = instr_valid & instr_ready.
  - On an edge with imem_en high: inflight ←1, and the PC of the request is recorded; PC ← PC+1, modulo 2^PC_W (0xFF wraps to 0x00 at PC_W=8).
- Capture:
  - On the edge following an issue, if inflight=1 and the request was not cancelled, push {imem_data, recorded PC} into the buffer.
  - If no new issue occurs on that edge, inflight ←0.
- Latency: PC presented at edge E0 → instr_valid high after edge E1 (2 cycles).
- Steady state: with instr_ready held high, throughput is 1 instruction per cycle.
- Buffer:
  - FIFO order; instr_out/instr_pc show the head.
  - Push and pop in the same cycle are both honoured.
  - Never pushes when full; the issue rule guarantees this.
  - Overflow is a design error; the bench asserts it never happens.
- Redirect (priority over issue and capture in its cycle):
  - A transfer completing in the redirect cycle still counts as transferred.
  - All other buffer entries are flushed.
  - Any in-flight response is discarded: not pushed on the next edge.
  - PC ← redirect_target; halted ←0; done ←0.
  - imem_en is low in the redirect cycle. The first fetch of the target occurs next cycle, and its instr_valid follows 2 cycles later.
- Halt:
  - When the pushed word equals HALT_INSTR: halted ←1, and no further imem_en.
  - A response already in flight when the halt word is pushed is discarded.
  - The halt word is issued normally. done ←1 on the edge it transfers, and stays 1 until reset or redirect.
- Stall: while instr_ready=0, instr_valid, instr_out and instr_pc hold stable. Fetching continues until the buffer plus in-flight reaches DEPTH.
- Simultaneous redirect & halt capture: redirect wins; halted stays 0.

Test Plan:
- Reset release, instr_ready=1, ROM[0..3]=0x012,0x034,0x056,0x078 → imem_addr 0,1,2,3 on consecutive cycles. instr_valid rises 2 cycles after the first imem_en. Transfers 0x012@0, 0x034@1, … one per cycle.
- Backpressure: hold instr_ready=0 for 5 cycles after the first valid → instr_out stays 0x012. imem_en drops after 2 outstanding entries (DEPTH=2). On release, 0x012, 0x034, 0x056 in order with no loss or duplication.
- Redirect: pulse redirect with target=0x40 while 0x056 is in flight and 0x034 is at head → 0x034 and 0x056 never appear. Next issued instr_pc=0x40, 2 cycles after the following imem_en.
- Wrap: redirect to 0xFE → instr_pc sequence 0xFE, 0xFF, 0x00.
- Halt: ROM[5]=0x1FF → no imem_en after the response at addr 5 is captured. Addr 6 is never issued. done=1 after 0x1FF transfers. A subsequent redirect to 0 clears done and resumes fetch.
- Async reset asserted mid-stream with the buffer full → instr_valid=0 and done=0 immediately. After release, fetch restarts at START_ADDR.
